// File: rtl/mrsc_rr_arbiter.sv
// Round-robin arbiter: NREQ valid/ready requesters share one registered output slot
// that drives a single valid/ready completer at up to one beat per cycle.
module mrsc_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  cpl_valid,
  output logic [DSIZE-1:0]      cpl_data,
  input  logic                  cpl_ready,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_p0, state_nxt;
  logic [DSIZE-1:0] data_p0, data_nxt;
  logic [IDW-1:0]   id_p0, id_nxt;
  logic [IDW-1:0]   last_ptr_p0, last_ptr_nxt;

  logic             load_en;
  logic             any_valid;
  logic [IDW-1:0]   winner;
  logic             found;
  logic [IDW-1:0]   idx;

  // Search starts one past the last winner, so the latest winner gets lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_ptr_p0) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_valid = |req_valid;
  assign load_en   = (state_p0 == EMPTY) | cpl_ready;

  always_comb begin
    req_ready         = '0;
    req_ready[winner] = load_en & any_valid;
  end

  always_comb begin
    state_nxt    = state_p0;
    data_nxt     = data_p0;
    id_nxt       = id_p0;
    last_ptr_nxt = last_ptr_p0;
    if (load_en) begin
      if (any_valid) begin
        state_nxt    = FULL;
        data_nxt     = req_data[int'(winner)*DSIZE +: DSIZE];
        id_nxt       = winner;
        last_ptr_nxt = winner;
      end else begin
        state_nxt    = EMPTY;
      end
    end
  end

  // Output slot stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_p0    <= EMPTY;
      data_p0     <= '0;
      id_p0       <= '0;
      last_ptr_p0 <= IDW'(NREQ - 1);
    end else begin
      state_p0    <= state_nxt;
      data_p0     <= data_nxt;
      id_p0       <= id_nxt;
      last_ptr_p0 <= last_ptr_nxt;
    end
  end

  assign cpl_valid = (state_p0 == FULL);
  assign cpl_data  = data_p0;
  assign grant_id  = id_p0;

endmodule
